timer_ctrl: RTL and testbench

- CPU-facing control stage for the one-shot `counter` block.
- Generates the counter's enable tick from a programmable prescaler.
- Sequences re-arm and start pulses to the counter, and consumes the counter's expiry line into a sticky interrupt flag with acknowledge, an expiry tally and optional auto-reload.
- Sits between the CPU register bus and one counter instance.

---
 rtl/timer_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_timer_ctrl.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_ctrl.sv
// timer_ctrl: CPU-facing control stage for a one-shot counter.
// Generates the counter enable tick from a programmable prescaler, sequences
// re-arm/start pulses, and turns counter expiry into a sticky, acknowledgeable
// interrupt flag with a saturating expiry tally and optional auto-reload.
// Optional build macro TIMER_CTRL_OVERRUN_EN adds the STAT.OVR overrun flag.
module timer_ctrl #(
  parameter int unsigned PRE_W = 8,
  parameter int unsigned CNT_W = 8
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_wr,
  input  logic [1:0] i_addr,
  input  logic [7:0] i_wdata,
  output logic [7:0] o_rdata,
  input  logic       i_line,
  output logic       o_cnt_rst,
  output logic       o_cnt_en,
  output logic       o_cnt_start,
  output logic       o_irq,
  output logic       o_busy
);

  localparam logic [1:0] ADDR_CTRL  = 2'd0;
  localparam logic [1:0] ADDR_PRE   = 2'd1;
  localparam logic [1:0] ADDR_STAT  = 2'd2;
  localparam logic [1:0] ADDR_TALLY = 2'd3;
  localparam logic [CNT_W-1:0] TALLY_MAX = '1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARM   = 2'd1,
    S_START = 2'd2,
    S_RUN   = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic             go_q;
  logic             auto_q;
  logic             ien_q;
  logic             flag_q;
  logic             ovr_q;
  logic [PRE_W-1:0] pre_q;
  logic [PRE_W-1:0] presc_q;
  logic [CNT_W-1:0] tally_q;

  logic wr_ctrl_c;
  logic wr_pre_c;
  logic wr_stat_c;
  logic wr_tally_c;
  logic stop_c;
  logic tick_c;
  logic expire_c;
  logic flag_clr_c;
  logic irq_src_c;

  // Register write decode and per-cycle events.
  assign wr_ctrl_c  = i_wr && (i_addr == ADDR_CTRL);
  assign wr_pre_c   = i_wr && (i_addr == ADDR_PRE);
  assign wr_stat_c  = i_wr && (i_addr == ADDR_STAT);
  assign wr_tally_c = i_wr && (i_addr == ADDR_TALLY);
  // A CTRL write clearing GO aborts a running sequence; it masks any expiry that cycle.
  assign stop_c     = wr_ctrl_c && !i_wdata[0] && (state_q == S_RUN);
  assign tick_c     = (state_q == S_RUN) && (presc_q == pre_q);
  assign expire_c   = (state_q == S_RUN) && i_line && !stop_c;
  assign flag_clr_c = wr_stat_c && i_wdata[1];

  // FSM state register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state and counter-facing outputs.
  always_comb begin
    state_d     = state_q;
    o_cnt_rst   = i_rst;
    o_cnt_en    = 1'b0;
    o_cnt_start = 1'b0;
    o_busy      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (wr_ctrl_c && i_wdata[0]) begin
          state_d = S_ARM;
        end
      end
      S_ARM: begin
        o_busy    = 1'b1;
        o_cnt_rst = 1'b1;
        state_d   = S_START;
      end
      S_START: begin
        o_busy      = 1'b1;
        o_cnt_start = 1'b1;
        o_cnt_en    = 1'b1;
        state_d     = S_RUN;
      end
      S_RUN: begin
        o_busy   = 1'b1;
        o_cnt_en = tick_c;
        if (stop_c) begin
          o_cnt_rst = 1'b1;
          state_d   = S_IDLE;
        end else if (expire_c) begin
          state_d = auto_q ? S_ARM : S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Control, prescaler divisor, flag and tally registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      go_q    <= 1'b0;
      auto_q  <= 1'b0;
      ien_q   <= 1'b0;
      flag_q  <= 1'b0;
      pre_q   <= '0;
      tally_q <= '0;
    end else begin
      if (wr_ctrl_c) begin
        auto_q <= i_wdata[1];
        ien_q  <= i_wdata[2];
        if (state_q == S_IDLE) begin
          go_q <= i_wdata[0];
        end
      end
      if (stop_c || (expire_c && !auto_q)) begin
        go_q <= 1'b0;
      end
      if (wr_pre_c) begin
        pre_q <= PRE_W'(i_wdata);
      end
      // Set has priority over a same-cycle acknowledge so no expiry is lost.
      if (expire_c) begin
        flag_q <= 1'b1;
      end else if (flag_clr_c) begin
        flag_q <= 1'b0;
      end
      // A tally write clears it; an expiry in that same cycle still counts.
      if (wr_tally_c) begin
        tally_q <= expire_c ? CNT_W'(1) : '0;
      end else if (expire_c && (tally_q != TALLY_MAX)) begin
        tally_q <= tally_q + CNT_W'(1);
      end
    end
  end

  // Prescaler: cleared on START, counts 0..PRE in RUN against the live divisor.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      presc_q <= '0;
    end else if (state_q == S_START) begin
      presc_q <= '0;
    end else if (state_q == S_RUN) begin
      presc_q <= tick_c ? '0 : presc_q + PRE_W'(1);
    end
  end

`ifdef TIMER_CTRL_OVERRUN_EN
  // Overrun: an expiry lands while the previous one is still unacknowledged.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ovr_q <= 1'b0;
    end else if (expire_c && flag_q && !flag_clr_c) begin
      ovr_q <= 1'b1;
    end else if (wr_stat_c && i_wdata[2]) begin
      ovr_q <= 1'b0;
    end
  end
  assign irq_src_c = flag_q | ovr_q;
`else
  assign ovr_q     = 1'b0;
  assign irq_src_c = flag_q;
`endif

  assign o_irq = irq_src_c & ien_q;

  // Combinational register read-back.
  always_comb begin
    o_rdata = '0;
    case (i_addr)
      ADDR_CTRL:  o_rdata = {5'b0, ien_q, auto_q, go_q};
      ADDR_PRE:   o_rdata = 8'(pre_q);
      ADDR_STAT:  o_rdata = {5'b0, ovr_q, flag_q, o_busy};
      ADDR_TALLY: o_rdata = 8'(tally_q);
      default:    o_rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_timer_ctrl.sv
// Scoreboard bench for timer_ctrl with a behavioural counter (threshold 4)
// feeding i_line. Define TIMER_CTRL_OVERRUN_EN to also cover the overrun flag.
module tb_timer_ctrl;

  localparam int THRESH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr = 1'b0;
  logic [1:0] addr = 2'd0;
  logic [7:0] wdata = 8'd0;
  logic [7:0] rdata;
  logic       line = 1'b0;
  logic       cnt_rst, cnt_en, cnt_start, irq, busy;

  timer_ctrl #(.PRE_W(8), .CNT_W(8)) dut (
    .i_clk(clk), .i_rst(rst), .i_wr(wr), .i_addr(addr), .i_wdata(wdata),
    .o_rdata(rdata), .i_line(line), .o_cnt_rst(cnt_rst), .o_cnt_en(cnt_en),
    .o_cnt_start(cnt_start), .o_irq(irq), .o_busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] rdata;
    logic       crst;
    logic       en;
    logic       start;
    logic       irq;
    logic       busy;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   sb_on = 1'b0;
  bit   irq_seen;

  // Reference model: cycles since launch (0 idle, 1 arm, 2 start, >=3 run).
  int m_since, m_go, m_aut, m_ien, m_pre, m_flag, m_ovr, m_tally, m_p;
  // Behavioural one-shot counter driven by the expected outputs.
  int c_armed, c_cnt, c_line;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at t=%0t", nm, act, req, $time);
    end
  endtask

  task automatic model_reset();
    m_since = 0; m_go = 0; m_aut = 0; m_ien = 0; m_pre = 0;
    m_flag = 0; m_ovr = 0; m_tally = 0; m_p = 0;
  endtask

  // One clock cycle: drive inputs, queue the expected response, advance the models.
  task automatic cyc(input bit r, input bit w, input bit [1:0] a, input bit [7:0] wd,
                     input int line_force);
    exp_t e;
    bit ln, bsy, arm, st, run, tick, stop, expire, fclr, oclr;
    int old_aut;
    @(negedge clk);
    irq_seen = irq;
    ln = (line_force < 0) ? c_line[0] : line_force[0];
    rst = r; wr = w; addr = a; wdata = wd; line = ln;
    bsy  = (m_since != 0);
    arm  = (m_since == 1);
    st   = (m_since == 2);
    run  = (m_since >= 3);
    tick = run && (m_p == m_pre);
    stop = w && (a == 2'd0) && !wd[0] && run;
    e.crst  = r | arm | stop;
    e.en    = st | tick;
    e.start = st;
    e.busy  = bsy;
    e.irq   = ((m_flag != 0) || (m_ovr != 0)) && (m_ien != 0);
    case (a)
      2'd0:    e.rdata = {5'b0, m_ien[0], m_aut[0], m_go[0]};
      2'd1:    e.rdata = 8'(m_pre);
      2'd2:    e.rdata = {5'b0, m_ovr[0], m_flag[0], bsy};
      default: e.rdata = 8'(m_tally);
    endcase
    if (sb_on) sb_q.push_back(e);
    if (e.crst) begin
      c_armed = 0; c_cnt = 0; c_line = 0;
    end else if (st) begin
      c_armed = 1; c_cnt = 0;
    end else if (c_armed != 0 && e.en) begin
      c_cnt++;
      if (c_cnt >= THRESH) c_line = 1;
    end
    if (r) begin
      model_reset();
      return;
    end
    expire = run && ln && !stop;
    fclr   = w && (a == 2'd2) && wd[1];
    oclr   = w && (a == 2'd2) && wd[2];
`ifdef TIMER_CTRL_OVERRUN_EN
    if (expire && m_flag != 0 && !fclr) m_ovr = 1;
    else if (oclr) m_ovr = 0;
`else
    if (oclr) m_ovr = 0;
`endif
    if (fclr) m_flag = 0;
    if (expire) m_flag = 1;
    if (w && a == 2'd3) m_tally = expire ? 1 : 0;
    else if (expire && m_tally < 255) m_tally++;
    if (st) m_p = 0;
    else if (run) m_p = tick ? 0 : (m_p + 1) % 256;
    old_aut = m_aut;
    if (w && a == 2'd1) m_pre = wd;
    if (w && a == 2'd0) begin
      m_aut = wd[1];
      m_ien = wd[2];
      if (!bsy) m_go = wd[0];
    end
    if (!bsy) begin
      if (w && a == 2'd0 && wd[0]) m_since = 1;
    end else if (stop) begin
      m_since = 0; m_go = 0;
    end else if (expire) begin
      if (old_aut != 0) m_since = 1;
      else begin m_since = 0; m_go = 0; end
    end else if (m_since < 3) begin
      m_since++;
    end
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 2'd0, 8'd0, -1);
  endtask

  task automatic wreg(input bit [1:0] a, input bit [7:0] wd);
    cyc(1'b0, 1'b1, a, wd, -1);
  endtask

  task automatic rd(input bit [1:0] a, input bit [7:0] req, input string nm);
    cyc(1'b0, 1'b0, a, 8'd0, -1);
    #3;
    chk(nm, rdata, req);
  endtask

  // Idle until the next cycle will carry an expiry (RUN with i_line high).
  task automatic wait_exp();
    for (int k = 0; k < 200; k++) begin
      if (m_since >= 3 && c_line != 0) return;
      idle();
    end
    chk("wait_exp_timeout", 8'd0, 8'd1);
  endtask

  // Launch with the given CTRL value and measure cycles until o_irq rises.
  task automatic go_measure(input bit [7:0] ctrl, input int req_lat, input string nm);
    bit found = 1'b0;
    wreg(2'd0, ctrl);
    for (int k = 1; k <= 60; k++) begin
      idle();
      if (irq_seen) begin
        chk(nm, 8'(k), 8'(req_lat));
        found = 1'b1;
        break;
      end
    end
    if (!found) chk({nm, "_timeout"}, 8'd0, 8'(req_lat));
  endtask

  // Monitor: compares every presented cycle against the queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("rdata", rdata, e.rdata);
        chk("cnt_rst", 8'(cnt_rst), 8'(e.crst));
        chk("cnt_en", 8'(cnt_en), 8'(e.en));
        chk("cnt_start", 8'(cnt_start), 8'(e.start));
        chk("irq", 8'(irq), 8'(e.irq));
        chk("busy", 8'(busy), 8'(e.busy));
      end
    end
  end

  initial begin
    model_reset();
    c_armed = 0; c_cnt = 0; c_line = 0;
    cyc(1'b1, 1'b0, 2'd0, 8'd0, -1);
    sb_on = 1'b1;
    cyc(1'b1, 1'b0, 2'd0, 8'd0, -1);
    #3 chk("rst_cnt_rst", 8'(cnt_rst), 8'd1);
    for (int a = 0; a < 4; a++) rd(2'(a), 8'd0, "reset_reg");

    // One-shot, PRE=0.
    wreg(2'd1, 8'd0);
    go_measure(8'h05, 8, "lat_pre0");
    rd(2'd0, 8'h04, "ctrl_go_cleared");
    rd(2'd2, 8'h02, "stat_flag");
    rd(2'd3, 8'd1, "tally_one");
    wreg(2'd2, 8'h02);

    // One-shot, PRE=2: expiry 8 cycles later.
    wreg(2'd1, 8'd2);
    rd(2'd1, 8'd2, "pre_rb");
    go_measure(8'h05, 16, "lat_pre2");
    wreg(2'd2, 8'h02);

    // Auto-reload, three expiries, then stop.
    wreg(2'd1, 8'd0);
    wreg(2'd3, 8'd0);
    wreg(2'd0, 8'h07);
    for (int i = 0; i < 3; i++) begin
      wait_exp();
      idle();
      wreg(2'd2, 8'h02);
    end
    rd(2'd3, 8'd3, "tally_three");
    wait_exp();
    wreg(2'd0, 8'h00);
    #3 chk("stop_cnt_rst", 8'(cnt_rst), 8'd1);
    rd(2'd2, 8'h00, "stat_after_stop");

    // Expiry coinciding with a FLAG acknowledge: set wins.
    wreg(2'd0, 8'h07);
    wait_exp();
    wreg(2'd2, 8'h02);
    rd(2'd2, 8'h03, "flag_set_wins");

    // Saturate the tally, then clear it with a write.
    for (int i = 0; i < 260; i++) begin
      wait_exp();
      idle();
    end
    wait_exp();
    wreg(2'd0, 8'h00);
    rd(2'd3, 8'hFF, "tally_sat");
    wreg(2'd3, 8'h5A);
    rd(2'd3, 8'h00, "tally_clr");

    // Reset in the middle of a run.
    wreg(2'd0, 8'h05);
    repeat (4) idle();
    cyc(1'b1, 1'b0, 2'd0, 8'd0, -1);
    #3 chk("midrst_cnt_rst", 8'(cnt_rst), 8'd1);
    cyc(1'b1, 1'b0, 2'd0, 8'd0, -1);
    #3 chk("midrst_busy", 8'(busy), 8'd0);
    chk("midrst_irq", 8'(irq), 8'd0);
    chk("midrst_hold", 8'(cnt_rst), 8'd1);
    for (int a = 0; a < 4; a++) rd(2'(a), 8'd0, "midrst_reg");
    repeat (4) idle();

`ifdef TIMER_CTRL_OVERRUN_EN
    // Second expiry with FLAG still set raises OVR.
    wreg(2'd0, 8'h07);
    wait_exp();
    idle();
    wait_exp();
    idle();
    rd(2'd2, 8'h07, "ovr_set");
    wreg(2'd2, 8'h06);
    rd(2'd2, 8'h01, "ovr_clr");
    #0 chk("ovr_irq_clr", 8'(irq), 8'd0);
    wait_exp();
    wreg(2'd0, 8'h00);
`endif

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      bit r, w;
      bit [1:0] a;
      bit [7:0] wd;
      int lf;
      r  = ($urandom_range(0, 399) == 0);
      w  = ($urandom_range(0, 7) == 0);
      a  = 2'($urandom_range(0, 3));
      wd = 8'($urandom);
      if (a == 2'd0 && $urandom_range(0, 9) < 7) wd[0] = 1'b1;
      if (a == 2'd1 && $urandom_range(0, 9) < 8) wd = 8'($urandom_range(0, 3));
      lf = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 1)) : -1;
      cyc(r, w, a, wd, lf);
    end

    repeat (3) @(negedge clk);
    #4;
    chk("sb_drain", 8'(sb_q.size()), 8'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
